// File: rtl/fp_expand_seq_if.sv
// Handshake bundle for the compact-float expander: code in (S/E/F), two's complement word out.
interface fp_expand_seq_if #(
  parameter int D_W = 12,
  parameter int E_W = 3,
  parameter int F_W = 4
);
  logic           in_valid;
  logic           in_ready;
  logic           S;
  logic [E_W-1:0] E;
  logic [F_W-1:0] F;
  logic           out_valid;
  logic           out_ready;
  logic [D_W-1:0] D;
  logic           busy;

  modport master (
    output in_valid, S, E, F, out_ready,
    input  in_ready, out_valid, D, busy
  );

  modport slave (
    input  in_valid, S, E, F, out_ready,
    output in_ready, out_valid, D, busy
  );
endinterface

// File: rtl/fp_expand_seq.sv
// Sequential expander: rebuilds (-1)^S * F * 2^E as a D_W-bit two's complement word,
// one left shift per clock, with valid/ready on both sides.
module fp_expand_seq #(
  parameter int D_W = 12,
  parameter int E_W = 3,
  parameter int F_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  fp_expand_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state, state_nxt;
  logic [D_W-1:0] acc, d_q;
  logic [E_W-1:0] cnt;
  logic           sign, out_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.in_valid)  state_nxt = SHIFT;
      SHIFT:   if (cnt == '0)     state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Magnitude never exceeds F_max << E_max, which stays below 2^(D_W-1): no saturation needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      cnt         <= '0;
      sign        <= 1'b0;
      d_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.in_valid) begin
          acc  <= {{(D_W-F_W){1'b0}}, bus.F};
          cnt  <= bus.E;
          sign <= bus.S;
        end
        SHIFT: if (cnt != '0) begin
          acc <= acc << 1;
          cnt <= cnt - E_W'(1);
        end else begin
          d_q         <= sign ? (~acc + D_W'(1)) : acc;
          out_valid_q <= 1'b1;
        end
        DONE: if (bus.out_ready) out_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.D         = d_q;
endmodule

// File: tb/tb_fp_expand_seq.sv
// Scenario bench for fp_expand_seq: expected words queued at accept, popped when out_valid shows.
module tb_fp_expand_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_expand_seq_if #(.D_W(12), .E_W(3), .F_W(4)) bus ();
  fp_expand_seq #(.D_W(12), .E_W(3), .F_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;
  logic [11:0] exp_q[$];

  function automatic logic [11:0] model(input logic s, input logic [2:0] e, input logic [3:0] f);
    int m;
    m = int'(f) * (1 << e);
    if (s) m = -m;
    return m[11:0];
  endfunction

  // Drive one code at a negedge, let the accept edge pass, then scramble the inputs.
  task automatic accept(input logic s, input logic [2:0] e, input logic [3:0] f);
    bus.in_valid = 1'b1; bus.S = s; bus.E = e; bus.F = f;
    exp_q.push_back(model(s, e, f));
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    bus.S = 1'($urandom); bus.E = 3'($urandom); bus.F = 4'($urandom);
  endtask

  // Edges since the accept edge until out_valid is seen; timeout after 20.
  task automatic wait_out(output int lat, output bit to);
    lat = 0; to = 1'b0;
    while (!bus.out_valid) begin
      if (lat > 20) begin to = 1'b1; break; end
      @(posedge clk); @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.D !== 12'h000 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset: ov=%b D=%h rdy=%b busy=%b, want 0 000 1 0", bus.out_valid, bus.D, bus.in_ready, bus.busy);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat; bit to; logic [11:0] e;
    bus.out_ready = 1'b1;
    accept(1'b0, 3'd0, 4'd5);
    total++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL basic_busy: busy=%b rdy=%b, want 1 0", bus.busy, bus.in_ready);
    end
    wait_out(lat, to);
    total++;
    if (to || lat != 1) begin bad++; $display("FAIL basic_lat: got %0d (timeout=%0d), want 1", lat, to); end
    e = exp_q.pop_front();
    total++;
    if (bus.D !== e || e !== 12'h005) begin bad++; $display("FAIL basic_D: got %h, want 005", bus.D); end
    @(posedge clk); @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL basic_idle: ov=%b rdy=%b, want 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_code(input string name, input logic s, input logic [2:0] e, input logic [3:0] f,
                           input logic [11:0] want);
    int lat; bit to; logic [11:0] x;
    bus.out_ready = 1'b1;
    accept(s, e, f);
    wait_out(lat, to);
    total++;
    if (to || lat != int'(e) + 1) begin bad++; $display("FAIL %s_lat: got %0d, want %0d", name, lat, int'(e) + 1); end
    x = exp_q.pop_front();
    total++;
    if (bus.D !== x || x !== want) begin bad++; $display("FAIL %s_D: got %h, want %h", name, bus.D, want); end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_backpressure;
    int lat; bit to; logic [11:0] x;
    bus.out_ready = 1'b0;
    accept(1'b0, 3'd4, 4'd9);
    wait_out(lat, to);
    total++;
    if (to || lat != 5) begin bad++; $display("FAIL bp_lat: got %0d, want 5", lat); end
    x = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0]; bus.S = 1'b1; bus.E = 3'd1; bus.F = 4'd3;
      @(posedge clk); @(negedge clk);
      total++;
      if (bus.D !== 12'h090 || bus.D !== x || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d: D=%h ov=%b rdy=%b, want 090 1 0", i, bus.D, bus.out_valid, bus.in_ready);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.D !== 12'h090) begin
      bad++; $display("FAIL bp_release: ov=%b rdy=%b D=%h, want 0 1 090", bus.out_valid, bus.in_ready, bus.D);
    end
    @(posedge clk); @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL bp_ignored: busy=%b, want 0", bus.busy); end
  endtask

  task automatic test_reset_mid;
    bus.out_ready = 1'b1;
    accept(1'b0, 3'd6, 4'd3);
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    total++;
    if (bus.out_valid !== 1'b0 || bus.D !== 12'h000 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL rst_mid: ov=%b D=%h rdy=%b, want 0 000 1", bus.out_valid, bus.D, bus.in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    test_code("post_rst", 1'b1, 3'd2, 4'd7, 12'hFE4);
  endtask

  task automatic test_back_to_back;
    int lat; bit to; logic [11:0] x; int errs;
    logic [7:0] c;
    errs = 0;
    bus.out_ready = 1'b1;
    for (int code = 0; code < 256; code++) begin
      c = 8'(code);
      accept(c[7], c[6:4], c[3:0]);
      wait_out(lat, to);
      x = exp_q.pop_front();
      total++;
      if (to || lat != int'(c[6:4]) + 1 || bus.D !== x) begin
        bad++; errs++;
        if (errs < 10)
          $display("FAIL sweep code=%h: D=%h lat=%0d, want %h lat=%0d", c, bus.D, lat, x, int'(c[6:4]) + 1);
      end
      @(posedge clk); @(negedge clk);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.S = 1'b0; bus.E = '0; bus.F = '0; bus.out_ready = 1'b0;
    test_reset;
    test_basic;
    test_code("maxneg", 1'b1, 3'd7, 4'd15, 12'h880);
    test_code("maxpos", 1'b0, 3'd7, 4'd15, 12'h780);
    test_code("zero", 1'b1, 3'd3, 4'd0, 12'h000);
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL queue_left: %0d entries, want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
